// File: rtl/param_counter.sv
// Up/down counter with programmable limit, wrap or saturate, one-cycle terminal pulse and sticky overflow.
// Optional enable prescaler is compiled in when COUNTER_PRESCALER_EN is defined.
module param_counter #(
  parameter int WIDTH      = 16,
  parameter bit SATURATE   = 1'b0,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  clr_ovf,
`ifdef COUNTER_PRESCALER_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      out,
  output logic                  tc,
  output logic                  ovf
);

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  if (WIDTH < 2 || WIDTH > 32 || PRESCALE_W < 1) begin : g_bad_cfg
    $error("param_counter: illegal parameter set");
  end

  logic             step_s;
  logic             term_s;
  logic [WIDTH-1:0] next_out_s;

`ifdef COUNTER_PRESCALER_EN
  logic [PRESCALE_W-1:0] psc_r;

  // Step strobe: one enabled cycle in every prescale+1.
  always_comb begin
    step_s = en & (psc_r == prescale);
  end

  // Prescaler count; restarts on reset or load, frozen while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      psc_r <= {PRESCALE_W{1'b0}};
    end else if (load) begin
      psc_r <= {PRESCALE_W{1'b0}};
    end else if (en) begin
      if (psc_r == prescale) begin
        psc_r <= {PRESCALE_W{1'b0}};
      end else begin
        psc_r <= psc_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      end
    end else begin
      psc_r <= psc_r;
    end
  end
`else
  // Step strobe: every enabled cycle.
  always_comb begin
    step_s = en;
  end
`endif

  // Next count and terminal detection; out >= limit also catches a limit lowered below out.
  always_comb begin
    term_s     = 1'b0;
    next_out_s = out;
    if (up) begin
      if (out >= limit) begin
        term_s = 1'b1;
        if (SATURATE) begin
          next_out_s = limit;
        end else begin
          next_out_s = ZERO;
        end
      end else begin
        next_out_s = out + ONE;
      end
    end else begin
      if (out == ZERO) begin
        term_s = 1'b1;
        if (SATURATE) begin
          next_out_s = ZERO;
        end else begin
          next_out_s = limit;
        end
      end else begin
        next_out_s = out - ONE;
      end
    end
  end

  // Count, terminal pulse and sticky flag; a terminal event beats clr_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= ZERO;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      out <= load_val;
      tc  <= 1'b0;
      ovf <= ovf & ~clr_ovf;
    end else if (step_s) begin
      out <= next_out_s;
      tc  <= term_s;
      ovf <= term_s | (ovf & ~clr_ovf);
    end else begin
      out <= out;
      tc  <= 1'b0;
      ovf <= ovf & ~clr_ovf;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: a wrapping and a saturating instance share stimulus.
module tb_param_counter;

  logic        clk = 1'b0;
  logic        rst, en, up, load, clr_ovf;
  logic [15:0] load_val, limit;
`ifdef COUNTER_PRESCALER_EN
  logic [7:0]  prescale;
  logic [7:0]  m_psc;
`endif
  logic [15:0] out_w, out_s;
  logic        tc_w, tc_s, ovf_w, ovf_s;

  typedef struct packed {
    logic [15:0] out;
    logic        tc;
    logic        ovf;
  } exp_t;

  exp_t        q_exp[2][$];
  logic [15:0] m_out[2];
  logic        m_tc[2];
  logic        m_ovf[2];
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(16), .SATURATE(1'b0), .PRESCALE_W(8)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .clr_ovf(clr_ovf),
`ifdef COUNTER_PRESCALER_EN
    .prescale(prescale),
`endif
    .out(out_w), .tc(tc_w), .ovf(ovf_w));

  param_counter #(.WIDTH(16), .SATURATE(1'b1), .PRESCALE_W(8)) u_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .limit(limit), .clr_ovf(clr_ovf),
`ifdef COUNTER_PRESCALER_EN
    .prescale(prescale),
`endif
    .out(out_s), .tc(tc_s), .ovf(ovf_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model the edge from the current inputs, queue expectations, clock, then compare.
  task automatic tick();
    logic        stp;
    logic        trm;
    logic [15:0] nx;
    exp_t        e;
`ifdef COUNTER_PRESCALER_EN
    stp = en && (m_psc == prescale);
`else
    stp = en;
`endif
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_out[k] = 16'h0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
      end else if (load) begin
        m_out[k] = load_val; m_tc[k] = 1'b0;
        if (clr_ovf) m_ovf[k] = 1'b0;
      end else if (stp) begin
        trm = 1'b0;
        if (up) begin
          if (m_out[k] < limit) nx = m_out[k] + 16'd1;
          else begin trm = 1'b1; nx = (k == 1) ? limit : 16'h0; end
        end else begin
          if (m_out[k] != 16'h0) nx = m_out[k] - 16'd1;
          else begin trm = 1'b1; nx = (k == 1) ? 16'h0 : limit; end
        end
        m_out[k] = nx;
        m_tc[k]  = trm;
        m_ovf[k] = trm | (m_ovf[k] & ~clr_ovf);
      end else begin
        m_tc[k] = 1'b0;
        if (clr_ovf) m_ovf[k] = 1'b0;
      end
      e.out = m_out[k]; e.tc = m_tc[k]; e.ovf = m_ovf[k];
      q_exp[k].push_back(e);
    end
`ifdef COUNTER_PRESCALER_EN
    if (rst || load) m_psc = 8'h0;
    else if (en) m_psc = (m_psc == prescale) ? 8'h0 : m_psc + 8'd1;
`endif
    @(posedge clk);
    #1;
    e = q_exp[0].pop_front();
    chk("wrap_out", {16'h0, out_w}, {16'h0, e.out});
    chk("wrap_tc",  {31'h0, tc_w},  {31'h0, e.tc});
    chk("wrap_ovf", {31'h0, ovf_w}, {31'h0, e.ovf});
    e = q_exp[1].pop_front();
    chk("sat_out",  {16'h0, out_s}, {16'h0, e.out});
    chk("sat_tc",   {31'h0, tc_s},  {31'h0, e.tc});
    chk("sat_ovf",  {31'h0, ovf_s}, {31'h0, e.ovf});
  endtask

  task automatic set_in(input logic i_en, input logic i_up, input logic i_load,
                        input logic [15:0] i_lv, input logic [15:0] i_lim, input logic i_clr);
    en = i_en; up = i_up; load = i_load; load_val = i_lv; limit = i_lim; clr_ovf = i_clr;
  endtask

  initial begin
    logic [15:0] seq_up[7];
    logic [15:0] seq_dn[4];
    logic [15:0] seq_sat[6];
    seq_up  = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0, 16'd1};
    seq_dn  = '{16'd1, 16'd0, 16'd9, 16'd8};
    seq_sat = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3, 16'd3};
    for (int k = 0; k < 2; k++) begin
      m_out[k] = 16'h0; m_tc[k] = 1'b0; m_ovf[k] = 1'b0;
    end
`ifdef COUNTER_PRESCALER_EN
    prescale = 8'd0;
    m_psc    = 8'd0;
`endif
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 16'd5, 1'b0);
    tick(); tick();
    chk("rst_out", {16'h0, out_w}, 32'h0);
    chk("rst_ovf", {31'h0, ovf_w}, 32'h0);
    rst = 1'b0;

    // Wrap at limit 5 counting up.
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("up_seq", {16'h0, out_w}, {16'h0, seq_up[i]});
      chk("up_tc",  {31'h0, tc_w},  (i == 5) ? 32'h1 : 32'h0);
      chk("up_ovf", {31'h0, ovf_w}, (i >= 5) ? 32'h1 : 32'h0);
    end

    // Load 2 then count down through zero with limit 9.
    set_in(1'b0, 1'b0, 1'b1, 16'd2, 16'd9, 1'b0);
    tick();
    chk("dn_load", {16'h0, out_w}, 32'd2);
    set_in(1'b1, 1'b0, 1'b0, 16'd0, 16'd9, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dn_seq", {16'h0, out_w}, {16'h0, seq_dn[i]});
      chk("dn_tc",  {31'h0, tc_w},  (i == 2) ? 32'h1 : 32'h0);
    end

    // Load wins over en; terminal event beats clr_ovf; clr_ovf alone clears.
    set_in(1'b1, 1'b1, 1'b1, 16'hABCD, 16'd9, 1'b0);
    tick();
    chk("load_pri", {16'h0, out_w}, 32'hABCD);
    chk("load_tc",  {31'h0, tc_w},  32'h0);
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 16'd0, 1'b1);
    tick();
    chk("clr_vs_term", {31'h0, ovf_w}, 32'h1);
    set_in(1'b0, 1'b1, 1'b0, 16'h0, 16'd0, 1'b1);
    tick();
    chk("clr_alone", {31'h0, ovf_w}, 32'h0);

    // Limit 0: every step is terminal and out stays 0 in both directions.
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'd0, 1'b0);
    tick(); tick();
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 16'd0, 1'b0);
    tick();
    chk("lim0_out", {16'h0, out_w}, 32'h0);
    chk("lim0_tc",  {31'h0, tc_w},  32'h1);

    // Full-scale limit wraps without leaking a carry.
    set_in(1'b0, 1'b1, 1'b1, 16'hFFFE, 16'hFFFF, 1'b0);
    tick();
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 16'hFFFF, 1'b0);
    tick(); tick();
    chk("fs_wrap", {16'h0, out_w}, 32'h0);
    chk("fs_tc",   {31'h0, tc_w},  32'h1);

    // Reset mid-count with ovf set.
    set_in(1'b0, 1'b1, 1'b1, 16'h1234, 16'hFFFF, 1'b0);
    tick();
    rst = 1'b1;
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    chk("mid_rst_out", {16'h0, out_w}, 32'h0);
    chk("mid_rst_tc",  {31'h0, tc_w},  32'h0);
    chk("mid_rst_ovf", {31'h0, ovf_w}, 32'h0);
    rst = 1'b0;

    // Saturating instance: hold at limit 3, then hold at 0 counting down.
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 16'd3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sat_seq", {16'h0, out_s}, {16'h0, seq_sat[i]});
      chk("sat_tcp", {31'h0, tc_s},  (i >= 3) ? 32'h1 : 32'h0);
    end
    set_in(1'b0, 1'b0, 1'b1, 16'h0, 16'd3, 1'b0);
    tick();
    set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_dn_out", {16'h0, out_s}, 32'h0);
      chk("sat_dn_tc",  {31'h0, tc_s},  32'h1);
    end

`ifdef COUNTER_PRESCALER_EN
    // Prescale 2: steps on every third enabled cycle, paused while en is low.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    prescale = 8'd2;
    set_in(1'b1, 1'b1, 1'b0, 16'h0, 16'd100, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk("psc_seq", {16'h0, out_w}, i / 3);
    end
    tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
    chk("psc_hold", {16'h0, out_w}, 32'd3);
    tick();
    chk("psc_resume", {16'h0, out_w}, 32'd4);
`endif

    // Random mix checked against the model.
    for (int i = 0; i < 300; i++) begin
      rst = ($urandom_range(0, 40) == 0);
      set_in($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
             16'($urandom_range(0, 15)), 16'($urandom_range(0, 12)), $urandom_range(0, 7) == 0);
`ifdef COUNTER_PRESCALER_EN
      prescale = 8'($urandom_range(0, 3));
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter width in bits, legal 2..32.
REQ-002 SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-003 SHALL have parameter PRESCALE_W, default 8: prescaler width; used only when COUNTER_PRESCALER_EN is defined.
REQ-004 SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port en  input  1  count enable.
REQ-007 SHALL have port up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value written on load.
REQ-010 SHALL have port limit  input  WIDTH  terminal value for counting up and reload value for counting down.
REQ-011 SHALL have port clr_ovf  input  1  clears sticky ovf.
REQ-012 SHALL have port prescale  input  PRESCALE_W  divide ratio minus one; present only with COUNTER_PRESCALER_EN.
REQ-013 SHALL have port out  output  WIDTH  registered count.
REQ-014 SHALL have port tc  output  1  registered one-cycle terminal-count pulse.
REQ-015 SHALL have port ovf  output  1  registered sticky overflow/underflow flag.

Function
REQ-016 SHALL define "step" as en=1 in a cycle, unless COUNTER_PRESCALER_EN is defined (see REQ-032).
REQ-017 SHALL apply per-cycle priority: rst > load > step > hold.
REQ-018 SHALL, on load, set out=load_val, clear the prescaler, and generate no tc and no ovf change; en is ignored in that cycle.
REQ-019 SHALL, on step with up=1 and out<limit, set out=out+1.
REQ-020 SHALL, on step with up=1 and out>=limit: set out=0 if SATURATE=0, else set out=limit; this is a terminal event.
REQ-021 SHALL, on step with up=0 and out>0, set out=out-1.
REQ-022 SHALL, on step with up=0 and out==0: set out=limit if SATURATE=0, else hold out=0; this is a terminal event.
REQ-023 SHALL set tc=1 in the cycle after a terminal event, for exactly one cycle per event; back-to-back terminal events give consecutive tc pulses.
REQ-024 SHALL set ovf=1 on every terminal event and hold it until clr_ovf or rst; when a terminal event and clr_ovf occur in the same cycle, ovf SHALL end at 1.
REQ-025 SHALL, with limit=0 and SATURATE=0, keep out=0 and flag a terminal event on every step in either direction.
REQ-026 SHALL sample limit combinationally each step; a limit change takes effect on the next step with no other side effect.
REQ-027 SHALL perform all arithmetic modulo 2^WIDTH with no carry leaking beyond WIDTH bits; out=2^WIDTH-1 with limit=2^WIDTH-1 counting up is terminal.
REQ-028 SHALL hold out, tc=0, and ovf when no load and no step occur.

Reset
REQ-029 SHALL, while rst=1 at posedge clk, set out=0, tc=0, ovf=0, and prescaler count=0, overriding all other inputs.
REQ-030 SHALL, when rst is asserted mid-count, take effect on that edge and discard any pending terminal pulse; the first step may occur in the cycle after rst deasserts.

Configuration
REQ-031 SHALL compile the prescaler in only when macro COUNTER_PRESCALER_EN is defined.
REQ-032 SHALL, with COUNTER_PRESCALER_EN defined, keep a PRESCALE_W-bit internal count psc: when en=1 and psc==prescale, a step occurs and psc becomes 0; when en=1 and psc!=prescale, psc increments; when en=0, psc holds. A step therefore occurs every prescale+1 enabled cycles, and prescale=0 steps every enabled cycle.
REQ-033 SHALL, with COUNTER_PRESCALER_EN undefined, omit the prescale port and psc register, so a step equals en.

Verification
REQ-034 SHALL cover: WIDTH=16, SATURATE=0, limit=5, up=1, en=1 for 7 cycles after rst -> out 1,2,3,4,5,0,1; tc high only in the cycle after out went 5->0; ovf=1 thereafter.
REQ-035 SHALL cover: SATURATE=1, limit=3, up=1, en=1 for 6 cycles -> out 1,2,3,3,3,3; tc pulses on each of the 3 saturated steps; up=0 from 0 -> out stays 0 with tc pulses.
REQ-036 SHALL cover: SATURATE=0, limit=9, load=1 with load_val=2, then up=0 with en=1 for 4 cycles -> out 2,1,0,9,8; tc once after the 0->9 step.
REQ-037 SHALL cover: load and en both high with load_val=0xABCD -> out=0xABCD, no step; ovf=1 with clr_ovf and a terminal event in the same cycle -> ovf stays 1; clr_ovf alone -> ovf=0.
REQ-038 SHALL cover: rst=1 asserted with out=0x1234 and ovf=1 -> next cycle out=0, tc=0, ovf=0.
REQ-039 SHALL cover: COUNTER_PRESCALER_EN defined, prescale=2, en=1 for 9 cycles -> out increments on cycles 3, 6, 9 only; en=0 for 2 cycles mid-sequence delays the next step by 2 cycles.
